decoder_n_scan: RTL and testbench

- Parametrised, registered N-to-OUT_COUNT one-hot decoder with two modes.
- Direct mode: a strobed select code is latched and decoded.
- Scan mode: an internal sequencer walks the outputs in order, holding each for a programmable dwell time.
- Used for chip-select, row-select and LED/keypad scanning wherever a fixed combinational decoder is insufficient.

---
 rtl/decoder_n_scan.sv | 87 ++++++++
 tb/tb_decoder_n_scan.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/decoder_n_scan.sv
// decoder_n_scan: registered one-hot decoder with direct-load and timed scan modes; ports Clock_In/Reset_In (async high), Enable_In, Mode_In, Encoded_Value_In, Load_In, Start_In, Stop_In, Wrap_In, Dwell_In -> Data_Out, Index_Out, Invalid_Out, Busy_Out, Done_Out; `DECODER_N_SCAN_TRISTATE_EN floats Data_Out while disabled
module decoder_n_scan #(
  parameter int SEL_WIDTH   = 3,
  parameter int OUT_COUNT   = 8,
  parameter int DWELL_WIDTH = 8
) (
  input  logic                   Clock_In,
  input  logic                   Reset_In,
  input  logic                   Enable_In,
  input  logic                   Mode_In,
  input  logic [SEL_WIDTH-1:0]   Encoded_Value_In,
  input  logic                   Load_In,
  input  logic                   Start_In,
  input  logic                   Stop_In,
  input  logic                   Wrap_In,
  input  logic [DWELL_WIDTH-1:0] Dwell_In,
  output logic [OUT_COUNT-1:0]   Data_Out,
  output logic [SEL_WIDTH-1:0]   Index_Out,
  output logic                   Invalid_Out,
  output logic                   Busy_Out,
  output logic                   Done_Out
);
  typedef enum logic {IDLE, SCAN} state_t;
  localparam logic [SEL_WIDTH-1:0] LAST = SEL_WIDTH'(OUT_COUNT - 1);
  state_t state;
  logic [SEL_WIDTH-1:0] idx;
  logic [DWELL_WIDTH-1:0] cnt, dwell;
  logic wrap, on, inv, done, code_ok;
  logic [OUT_COUNT-1:0] decoded;
  assign code_ok = {1'b0, Encoded_Value_In} < (SEL_WIDTH + 1)'(OUT_COUNT);
  always_ff @(posedge Clock_In or posedge Reset_In)
    if (Reset_In) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      dwell <= '0;
      wrap  <= 1'b0;
      on    <= 1'b0;
      inv   <= 1'b0;
      done  <= 1'b0;
    end else if (Enable_In) begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (!Mode_In && Load_In) begin
          idx <= Encoded_Value_In;
          on  <= code_ok;
          inv <= !code_ok;
        end else if (Mode_In && Start_In) begin
          dwell <= Dwell_In;
          wrap  <= Wrap_In;
          idx   <= '0;
          cnt   <= '0;
          on    <= 1'b1;
          inv   <= 1'b0;
          state <= SCAN;
        end
      end else if (Stop_In) begin
        state <= IDLE;
        idx   <= '0;
        cnt   <= '0;
        on    <= 1'b0;
      end else if (cnt == dwell) begin
        cnt <= '0;
        if (idx == LAST) begin
          done <= 1'b1;
          idx  <= '0;
          if (!wrap) begin
            state <= IDLE;
            on    <= 1'b0;
          end
        end else idx <= idx + 1'b1;
      end else cnt <= cnt + 1'b1;
    end
  always_comb begin
    decoded = '0;
    for (int i = 0; i < OUT_COUNT; i++) decoded[i] = idx == SEL_WIDTH'(i);
  end
`ifdef DECODER_N_SCAN_TRISTATE_EN
  assign Data_Out = !Enable_In ? 'z : on ? decoded : '0;
`else
  assign Data_Out = Enable_In && on ? decoded : '0;
`endif
  assign Index_Out   = idx;
  assign Invalid_Out = inv;
  assign Busy_Out    = state == SCAN;
  assign Done_Out    = done && Enable_In;
endmodule

// File: tb/tb_decoder_n_scan.sv
// tb_decoder_n_scan: scoreboard bench for decoder_n_scan (default 8-output instance plus a 6-output instance for invalid codes)
module tb_decoder_n_scan;
  logic clk = 1'b0, rst = 1'b1;
  logic en = 1'b1, mode = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0, wrap = 1'b0;
  logic [2:0] code = '0;
  logic [7:0] dwell_in = '0;
  logic [7:0] data;
  logic [5:0] data6;
  logic [2:0] index, index6;
  logic invalid, busy, done, invalid6, busy6, done6;
  typedef struct packed {logic [7:0] d; logic [2:0] i; logic v, b, o;} exp_t;
  exp_t sb[$];
  int n_vec = 0, n_err = 0;
  int m_scan, m_idx, m_on, m_inv, m_cnt, m_dw, m_wr, m_done;
  int hi[8], n_done, n_busy;
  always #5 clk = ~clk;
  decoder_n_scan dut (
    .Clock_In(clk), .Reset_In(rst), .Enable_In(en), .Mode_In(mode),
    .Encoded_Value_In(code), .Load_In(load), .Start_In(start), .Stop_In(stop),
    .Wrap_In(wrap), .Dwell_In(dwell_in), .Data_Out(data), .Index_Out(index),
    .Invalid_Out(invalid), .Busy_Out(busy), .Done_Out(done)
  );
  decoder_n_scan #(.OUT_COUNT(6)) dut6 (
    .Clock_In(clk), .Reset_In(rst), .Enable_In(en), .Mode_In(mode),
    .Encoded_Value_In(code), .Load_In(load), .Start_In(start), .Stop_In(stop),
    .Wrap_In(wrap), .Dwell_In(dwell_in), .Data_Out(data6), .Index_Out(index6),
    .Invalid_Out(invalid6), .Busy_Out(busy6), .Done_Out(done6)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    {m_scan, m_idx, m_on, m_inv, m_cnt, m_dw, m_wr, m_done} = '0;
  endtask
  task automatic tick();
    exp_t e;
    if (en) begin
      m_done = 0;
      if (!m_scan) begin
        if (!mode && load) begin
          m_idx = code; m_on = 1; m_inv = 0;
        end else if (mode && start) begin
          m_dw = dwell_in; m_wr = wrap; m_idx = 0; m_cnt = 0; m_on = 1; m_inv = 0; m_scan = 1;
        end
      end else if (stop) begin
        m_scan = 0; m_idx = 0; m_cnt = 0; m_on = 0;
      end else if (m_cnt == m_dw) begin
        m_cnt = 0;
        if (m_idx == 7) begin
          m_done = 1; m_idx = 0;
          if (!m_wr) begin m_scan = 0; m_on = 0; end
        end else m_idx++;
      end else m_cnt++;
    end
    e.d = (en && m_on) ? 8'(1 << m_idx) : 8'h00;
    e.i = 3'(m_idx);
    e.v = m_inv[0];
    e.b = m_scan[0];
    e.o = m_done[0] && en;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check("data", 32'(data), 32'(e.d));
    check("index", 32'(index), 32'(e.i));
    check("invalid", 32'(invalid), 32'(e.v));
    check("busy", 32'(busy), 32'(e.b));
    check("done", 32'(done), 32'(e.o));
    for (int k = 0; k < 8; k++) hi[k] += int'(data[k]);
    n_done += int'(done);
    n_busy += int'(busy);
  endtask
  task automatic clear_hist();
    for (int k = 0; k < 8; k++) hi[k] = 0;
    n_done = 0;
    n_busy = 0;
  endtask
  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask
  task automatic go(input logic [7:0] dw, input logic wr);
    mode = 1; start = 1; dwell_in = dw; wrap = wr;
    tick();
    start = 0;
  endtask
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_data", 32'(data), 0);
    check("rst_index", 32'(index), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 0;
    run(2);
    code = 5; load = 1; tick(); load = 0;
    check("direct5", 32'(data), 32'h20);
    code = 1; run(10);
    check("hold5", 32'(data), 32'h20);
    code = 7; load = 1; tick(); load = 0;
    check("inv6_data", 32'(data6), 0);
    check("inv6_flag", 32'(invalid6), 1);
    code = 2; load = 1; tick(); load = 0;
    check("ok6_data", 32'(data6), 32'h04);
    check("ok6_flag", 32'(invalid6), 0);
    en = 0; code = 6; load = 1; run(2); load = 0; en = 1; run(1);
    stop = 1; run(1); stop = 0;
    clear_hist();
    go(8'd2, 1'b0);
    run(24);
    for (int k = 0; k < 8; k++) check($sformatf("sweep_bit%0d", k), 32'(hi[k]), 3);
    check("sweep_done", 32'(n_done), 1);
    check("sweep_busy", 32'(n_busy), 24);
    check("sweep_end", 32'(data), 0);
    clear_hist();
    go(8'd0, 1'b1);
    run(16);
    check("wrap_done", 32'(n_done), 2);
    while (m_idx != 3) tick();
    stop = 1; tick(); stop = 0;
    check("stop_data", 32'(data), 0);
    check("stop_done", 32'(done), 0);
    check("stop_busy", 32'(busy), 0);
    run(2);
    go(8'd3, 1'b0);
    run(17);
    en = 0;
    run(5);
    check("frz_index", 32'(index), 4);
    check("frz_data", 32'(data), 0);
    en = 1;
    run(2);
    check("resume", 32'(data), 32'h10);
    run(1);
    check("advance", 32'(data), 32'h20);
    run(16);
    go(8'd1, 1'b1);
    while (m_idx != 6) tick();
    #2 rst = 1;
    #1;
    check("arst_data", 32'(data), 0);
    check("arst_index", 32'(index), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    #1 rst = 0;
    model_reset();
    go(8'd0, 1'b0);
    check("restart", 32'(data), 32'h01);
    run(9);
    mode = 0; code = 3; load = 1; start = 1; tick(); load = 0; start = 0;
    run(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
